// File: rtl/netwalk_pkt_in_queue.sv
// netwalk_pkt_in_queue: FWFT queue of table-missed headers with buffer ids and push/drop statistics
module netwalk_pkt_in_queue #(
  parameter int DPL_PKT_BIT_WIDTH = 608,
  parameter int OF_FLOW_TAG_WIDTH = 5,
  parameter int QUEUE_ADDR_WIDTH  = 3,
  parameter int BUF_ID_WIDTH      = 8,
  parameter int STAT_COUNTER_SIZE = 32
) (
  input  logic                          dpl_clk,
  input  logic                          dpl_reset,
  input  logic [DPL_PKT_BIT_WIDTH-1:0]  dpl_pkt_header_out,
  input  logic                          dpl_pkt_header_out_enable,
  input  logic                          dpl_of_table_missed,
  input  logic [OF_FLOW_TAG_WIDTH-1:0]  dpl_flow_tag,
  output logic [DPL_PKT_BIT_WIDTH-1:0]  pin_header,
  output logic [OF_FLOW_TAG_WIDTH-1:0]  pin_flow_tag,
  output logic [BUF_ID_WIDTH-1:0]       pin_buffer_id,
  output logic                          pin_valid,
  input  logic                          pin_ready,
  output logic [QUEUE_ADDR_WIDTH:0]     pin_queue_level,
  output logic                          pin_queue_full,
  output logic [STAT_COUNTER_SIZE-1:0]  pin_push_count,
  output logic [STAT_COUNTER_SIZE-1:0]  pin_drop_count,
  input  logic                          pin_clear_counters
);
  localparam int DEPTH = 2 ** QUEUE_ADDR_WIDTH;
  localparam int EW = DPL_PKT_BIT_WIDTH + OF_FLOW_TAG_WIDTH + BUF_ID_WIDTH;
  logic [EW-1:0] mem [DEPTH];
  logic [QUEUE_ADDR_WIDTH-1:0] rd_ptr, wr_ptr, rd_next;
  logic [QUEUE_ADDR_WIDTH:0] level, level_next;
  logic [BUF_ID_WIDTH-1:0] buf_id_ctr;
  logic [EW-1:0] wr_data, head_next;
  logic cap, push, pop;
  assign cap = dpl_pkt_header_out_enable & dpl_of_table_missed;
  assign push = cap & ~pin_queue_full;
  assign pop = pin_valid & pin_ready;
  assign wr_data = {dpl_pkt_header_out, dpl_flow_tag, buf_id_ctr};
  assign pin_queue_level = level;
  assign pin_queue_full = level == (QUEUE_ADDR_WIDTH+1)'(DEPTH);
  always_comb begin
    rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_next = level + (QUEUE_ADDR_WIDTH+1)'(push) - (QUEUE_ADDR_WIDTH+1)'(pop);
    head_next = level_next == '0 ? '0 : (push && wr_ptr == rd_next) ? wr_data : mem[rd_next];
  end
  always_ff @(posedge dpl_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge dpl_clk) begin
    if (!dpl_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      buf_id_ctr <= '0;
      pin_valid <= 1'b0;
      {pin_header, pin_flow_tag, pin_buffer_id} <= '0;
      pin_push_count <= '0;
      pin_drop_count <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + QUEUE_ADDR_WIDTH'(push);
      level <= level_next;
      buf_id_ctr <= buf_id_ctr + BUF_ID_WIDTH'(push);
      pin_valid <= level_next != '0;
      {pin_header, pin_flow_tag, pin_buffer_id} <= head_next;
      pin_push_count <= pin_clear_counters ? '0 :
                        (push && pin_push_count != '1) ? pin_push_count + 1'b1 : pin_push_count;
      pin_drop_count <= pin_clear_counters ? '0 :
                        (cap && pin_queue_full && pin_drop_count != '1) ? pin_drop_count + 1'b1 : pin_drop_count;
    end
  end
endmodule

// File: tb/tb_netwalk_pkt_in_queue.sv
// tb_netwalk_pkt_in_queue: directed scoreboard bench for the PACKET_IN queue
module tb_netwalk_pkt_in_queue;
  localparam int HW = 608, TW = 5, AW = 3, BW = 8, CW = 32, DEPTH = 8;
  typedef struct packed {
    logic [HW-1:0] hdr;
    logic [TW-1:0] tag;
    logic [BW-1:0] id;
  } ent_t;
  logic dpl_clk = 1'b0;
  logic dpl_reset = 1'b0;
  logic [HW-1:0] dpl_pkt_header_out = '0;
  logic dpl_pkt_header_out_enable = 1'b0;
  logic dpl_of_table_missed = 1'b0;
  logic [TW-1:0] dpl_flow_tag = '0;
  logic pin_ready = 1'b0;
  logic pin_clear_counters = 1'b0;
  logic [HW-1:0] pin_header;
  logic [TW-1:0] pin_flow_tag;
  logic [BW-1:0] pin_buffer_id;
  logic pin_valid;
  logic [AW:0] pin_queue_level;
  logic pin_queue_full;
  logic [CW-1:0] pin_push_count, pin_drop_count;
  ent_t sb[$];
  logic [BW-1:0] m_id = '0;
  logic [CW-1:0] m_push = '0, m_drop = '0;
  int compared = 0, mismatched = 0;
  netwalk_pkt_in_queue dut (
    .dpl_clk(dpl_clk), .dpl_reset(dpl_reset),
    .dpl_pkt_header_out(dpl_pkt_header_out),
    .dpl_pkt_header_out_enable(dpl_pkt_header_out_enable),
    .dpl_of_table_missed(dpl_of_table_missed), .dpl_flow_tag(dpl_flow_tag),
    .pin_header(pin_header), .pin_flow_tag(pin_flow_tag), .pin_buffer_id(pin_buffer_id),
    .pin_valid(pin_valid), .pin_ready(pin_ready), .pin_queue_level(pin_queue_level),
    .pin_queue_full(pin_queue_full), .pin_push_count(pin_push_count),
    .pin_drop_count(pin_drop_count), .pin_clear_counters(pin_clear_counters)
  );
  always #5 dpl_clk = ~dpl_clk;
  task automatic chk(input string name, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  function automatic logic [HW-1:0] rand_hdr();
    logic [HW-1:0] h;
    for (int i = 0; i < HW / 32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction
  task automatic check_state();
    ent_t e;
    e = sb.size() != 0 ? sb[0] : '0;
    chk("level", HW'(pin_queue_level), HW'(sb.size()));
    chk("valid", HW'(pin_valid), HW'(sb.size() != 0));
    chk("full", HW'(pin_queue_full), HW'(sb.size() == DEPTH));
    chk("head_hdr", pin_header, e.hdr);
    chk("head_tag", HW'(pin_flow_tag), HW'(e.tag));
    chk("head_id", HW'(pin_buffer_id), HW'(e.id));
    chk("push_count", HW'(pin_push_count), HW'(m_push));
    chk("drop_count", HW'(pin_drop_count), HW'(m_drop));
  endtask
  task automatic step(input logic en, input logic miss, input logic rdy, input logic clr, input logic [TW-1:0] tag);
    logic [HW-1:0] h;
    logic full;
    h = rand_hdr();
    @(negedge dpl_clk);
    dpl_pkt_header_out = h;
    dpl_pkt_header_out_enable = en;
    dpl_of_table_missed = miss;
    dpl_flow_tag = tag;
    pin_ready = rdy;
    pin_clear_counters = clr;
    full = sb.size() == DEPTH;
    if (rdy && sb.size() != 0) void'(sb.pop_front());
    if (en && miss) begin
      if (full) m_drop = m_drop + 1'b1;
      else begin
        sb.push_back('{hdr: h, tag: tag, id: m_id});
        m_id = m_id + 1'b1;
        m_push = m_push + 1'b1;
      end
    end
    if (clr) begin
      m_push = '0;
      m_drop = '0;
    end
    @(posedge dpl_clk);
    #1;
    check_state();
  endtask
  task automatic do_reset();
    @(negedge dpl_clk);
    dpl_reset = 1'b0;
    dpl_pkt_header_out_enable = 1'b0;
    dpl_of_table_missed = 1'b0;
    pin_clear_counters = 1'b0;
    sb.delete();
    m_id = '0;
    m_push = '0;
    m_drop = '0;
    @(posedge dpl_clk);
    #1;
    check_state();
    @(negedge dpl_clk);
    dpl_reset = 1'b1;
    pin_ready = 1'b0;
  endtask
  initial begin
    do_reset();
    for (int i = 1; i <= 3; i++) step(1, 1, 0, 0, TW'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, TW'(i + 8));
    step(1, 1, 1, 0, 5'd30);
    step(1, 0, 0, 0, 5'd20);
    step(0, 1, 0, 0, 5'd21);
    step(1, 1, 0, 1, 5'd22);
    step(0, 0, 1, 0, '0);
    step(1, 1, 0, 0, 5'd23);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, '0);
    for (int i = 0; i < 300; i++) step(1, 1, 1, 0, TW'(i));
    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, TW'(i));
    pin_ready = 1'b1;
    do_reset();
    step(1, 1, 0, 0, 5'd7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
